// File: rtl/ntt_job_arbiter.sv
// Round-robin arbiter sharing one NTT engine between two requesters.
// Sequences start/finish, steers memory traffic to the owner, and aborts hung jobs.
//
// state | meaning
// IDLE  | no job; arbitrate pending requests
// RUN   | engine started for owner; wait for finish edge or watchdog
// REL   | job complete; done pulse, release grant
// ABORT | watchdog expired; engine reset, done+err pulse
module ntt_job_arbiter #(
    parameter int LOGQ    = 64,
    parameter int LOGN    = 4,
    parameter int TIMEOUT = 4096,
    localparam int AW     = ((LOGN < 9) ? 9 : LOGN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_0,
    input  logic            req_1,
    input  logic            intt_0,
    input  logic            intt_1,
    input  logic [LOGQ-1:0] q_0,
    input  logic [LOGQ-1:0] q_1,
    input  logic [LOGQ-1:0] din0_0,
    input  logic [LOGQ-1:0] din1_0,
    input  logic [LOGQ-1:0] din0_1,
    input  logic [LOGQ-1:0] din1_1,
    output logic            gnt_0,
    output logic            gnt_1,
    output logic            done_0,
    output logic            done_1,
    output logic            err_0,
    output logic            err_1,
    output logic            wea_0,
    output logic            wea_1,
    output logic [AW-1:0]   mem_rd_addr,
    output logic [AW-1:0]   mem_wr_addr,
    output logic            ntt_rst,
    output logic            ntt_start,
    output logic            ntt_intt,
    output logic [LOGQ-1:0] ntt_q,
    output logic [LOGQ-1:0] ntt_din_0,
    output logic [LOGQ-1:0] ntt_din_1,
    input  logic [AW-1:0]   ntt_read_address,
    input  logic [AW-1:0]   ntt_write_address,
    input  logic            ntt_wea,
    input  logic            ntt_finish
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] REL   = 2'd2;
    localparam logic [1:0] ABORT = 2'd3;

    localparam bit          WD_EN   = (TIMEOUT != 0);
    localparam logic [31:0] WD_LOAD = 32'(TIMEOUT - 1);

    logic [1:0]  state;
    logic        owner;
    logic        rr;
    logic        fin_q;
    logic [31:0] wd_cnt;
    logic        win;
    logic        fin_edge;

    assign win      = (req_0 & req_1) ? rr : req_1;
    assign fin_edge = ntt_finish & ~fin_q;

    // Watchdog is a down-counter: loaded at grant, abort on terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            rr       <= 1'b0;
            fin_q    <= 1'b0;
            wd_cnt   <= '0;
            ntt_intt <= 1'b0;
            ntt_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_0 | req_1) begin
                        state    <= RUN;
                        owner    <= win;
                        ntt_intt <= win ? intt_1 : intt_0;
                        ntt_q    <= win ? q_1 : q_0;
                        wd_cnt   <= WD_LOAD;
                        fin_q    <= ntt_finish;
                    end
                end
                RUN: begin
                    fin_q <= ntt_finish;
                    if (fin_edge)
                        state <= REL;
                    else if (WD_EN && wd_cnt == '0)
                        state <= ABORT;
                    else
                        wd_cnt <= wd_cnt - 32'd1;
                end
                REL, ABORT: begin
                    rr    <= ~owner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt_0     = (state != IDLE) & ~owner;
    assign gnt_1     = (state != IDLE) &  owner;
    assign done_0    = ((state == REL) | (state == ABORT)) & ~owner;
    assign done_1    = ((state == REL) | (state == ABORT)) &  owner;
    assign err_0     = (state == ABORT) & ~owner;
    assign err_1     = (state == ABORT) &  owner;
    assign ntt_start = (state == RUN);
    assign ntt_rst   = rst | (state == ABORT);

    assign wea_0       = ntt_wea & (state == RUN) & ~owner;
    assign wea_1       = ntt_wea & (state == RUN) &  owner;
    assign ntt_din_0   = owner ? din0_1 : din0_0;
    assign ntt_din_1   = owner ? din1_1 : din1_0;
    assign mem_rd_addr = ntt_read_address;
    assign mem_wr_addr = ntt_write_address;

endmodule

// File: tb/tb_ntt_job_arbiter.sv
// Directed bench for ntt_job_arbiter; the bench plays the role of the NTT engine.
module tb_ntt_job_arbiter;
    localparam int LOGQ = 64;
    localparam int LOGN = 4;
    localparam int AW   = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_0, req_1, intt_0, intt_1;
    logic [LOGQ-1:0] q_0, q_1, din0_0, din1_0, din0_1, din1_1;
    logic            gnt_0, gnt_1, done_0, done_1, err_0, err_1, wea_0, wea_1;
    logic [AW-1:0]   mem_rd_addr, mem_wr_addr, ntt_read_address, ntt_write_address;
    logic            ntt_rst, ntt_start, ntt_intt, ntt_wea, ntt_finish;
    logic [LOGQ-1:0] ntt_q, ntt_din_0, ntt_din_1;

    int n_cmp = 0;
    int n_err = 0;
    int hi;

    ntt_job_arbiter #(.LOGQ(LOGQ), .LOGN(LOGN), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .req_1(req_1), .intt_0(intt_0), .intt_1(intt_1),
        .q_0(q_0), .q_1(q_1),
        .din0_0(din0_0), .din1_0(din1_0), .din0_1(din0_1), .din1_1(din1_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .done_0(done_0), .done_1(done_1),
        .err_0(err_0), .err_1(err_1), .wea_0(wea_0), .wea_1(wea_1),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
        .ntt_rst(ntt_rst), .ntt_start(ntt_start), .ntt_intt(ntt_intt), .ntt_q(ntt_q),
        .ntt_din_0(ntt_din_0), .ntt_din_1(ntt_din_1),
        .ntt_read_address(ntt_read_address), .ntt_write_address(ntt_write_address),
        .ntt_wea(ntt_wea), .ntt_finish(ntt_finish)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req_0 = 0; req_1 = 0; intt_0 = 0; intt_1 = 1;
        q_0 = 64'hFFFF_FFFF_0000_0001; q_1 = 64'h0000_0000_0C00_0001;
        din0_0 = 64'hA0; din1_0 = 64'hA1; din0_1 = 64'hB0; din1_1 = 64'hB1;
        ntt_read_address = '0; ntt_write_address = '0; ntt_wea = 0; ntt_finish = 0;
        tick(); tick();
        chk("rst_ntt_rst", ntt_rst, 1);
        rst = 1'b0;
        tick();
        chk("rst_gnt", {gnt_0, gnt_1}, 0);
        chk("rst_start", ntt_start, 0);
        chk("rst_q", ntt_q, 0);
        chk("rst_done_err", {done_0, done_1, err_0, err_1}, 0);
        chk("rst_ntt_rst_low", ntt_rst, 0);

        // single job on requester 0
        req_0 = 1;
        tick();
        chk("s_gnt0", gnt_0, 1);
        chk("s_start", ntt_start, 1);
        chk("s_q", ntt_q, 64'hFFFF_FFFF_0000_0001);
        chk("s_intt", ntt_intt, 0);
        ntt_read_address = 10'd5; ntt_write_address = 10'd9; ntt_wea = 1;
        tick(); tick();
        chk("s_start_hold", ntt_start, 1);
        chk("s_din0", ntt_din_0, 64'hA0);
        chk("s_din1", ntt_din_1, 64'hA1);
        chk("s_rd_addr", mem_rd_addr, 5);
        chk("s_wr_addr", mem_wr_addr, 9);
        chk("s_wea", {wea_0, wea_1}, 2'b10);
        ntt_finish = 1;
        tick();
        chk("s_rel_done", {done_0, done_1, err_0, err_1}, 4'b1000);
        chk("s_rel_start", ntt_start, 0);
        chk("s_rel_gnt", gnt_0, 1);
        chk("s_rel_wea", wea_0, 0);
        req_0 = 0;
        tick();
        chk("s_idle_gnt", gnt_0, 0);
        chk("s_idle_done", done_0, 0);
        ntt_wea = 0;

        // simultaneous requests after reset, finish still held high (stale)
        rst = 1; tick(); rst = 0;
        req_0 = 1; req_1 = 1;
        tick();
        chk("b_gnt", {gnt_0, gnt_1}, 2'b10);
        chk("b_intt0", ntt_intt, 0);
        tick(); tick();
        chk("b_stale_fin", ntt_start, 1);
        ntt_finish = 0; tick();
        ntt_finish = 1; tick();
        chk("b_done0", done_0, 1);
        chk("b_rel_start", ntt_start, 0);
        tick();
        chk("b_idle_start", ntt_start, 0);
        chk("b_idle_gnt", {gnt_0, gnt_1}, 0);
        tick();
        chk("b_rr_gnt1", {gnt_0, gnt_1}, 2'b01);
        chk("b_intt1", ntt_intt, 1);
        chk("b_q1", ntt_q, 64'h0000_0000_0C00_0001);

        // ownership of writes while requester 1 holds the grant
        ntt_wea = 1;
        tick();
        chk("w_wea_on", {wea_0, wea_1}, 2'b01);
        chk("w_din0", ntt_din_0, 64'hB0);
        chk("w_din1", ntt_din_1, 64'hB1);
        ntt_wea = 0;
        tick();
        chk("w_wea_off", {wea_0, wea_1}, 2'b00);
        ntt_wea = 1;
        ntt_finish = 0; tick();
        chk("w_wea_on2", {wea_0, wea_1}, 2'b01);
        ntt_wea = 0;
        ntt_finish = 1; tick();
        chk("w_done1", {done_0, done_1, err_1}, 3'b010);
        req_1 = 0;
        tick();

        // hung engine: requester 0 still requesting, finish low
        ntt_finish = 0;
        tick();
        chk("h_gnt0", gnt_0, 1);
        hi = 0;
        while (ntt_start === 1'b1 && hi < 40) begin
            hi++;
            tick();
        end
        chk("h_start_cycles", 64'(hi), 16);
        chk("h_abort", {ntt_rst, done_0, err_0, done_1, err_1}, 5'b11100);
        chk("h_abort_gnt", gnt_0, 1);
        req_0 = 0;
        tick();
        chk("h_idle", {ntt_rst, done_0, err_0, gnt_0, ntt_start}, 0);

        // reset in the middle of a job
        req_1 = 1;
        tick();
        chk("r_gnt1", gnt_1, 1);
        tick();
        rst = 1; req_1 = 0;
        tick();
        chk("r_outs", {gnt_0, gnt_1, done_0, done_1, err_0, err_1, ntt_start, ntt_intt}, 0);
        chk("r_q", ntt_q, 0);
        rst = 0;
        tick();
        chk("r_no_done", {done_0, done_1}, 0);
        req_1 = 1;
        tick();
        chk("r_fresh_gnt", {gnt_0, gnt_1}, 2'b01);
        ntt_finish = 1;
        tick();
        chk("r_fresh_done", {done_1, err_1}, 2'b10);
        req_1 = 0;
        tick();
        chk("r_final_idle", {gnt_1, ntt_start}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
